mt_seed_init: RTL
=================

# mt_seed_init

Seeding stage of the MT19937 generator. It sits directly upstream of the twist stage. On a start request it computes the 624-word initial state vector from a 32-bit seed and writes it into the shared state memory, one word per cycle. It then raises `done_init` so the top-level controller can move into the twist state (`current_state == 2'b10`).

## Interface
Parameters:
- `N`, 624: state vector length; also the number of words written.
- `INIT_MULT`, 32'd1812433253 (0x6C078965): seeding multiplier `f`.
- `SHIFT`, 30: right-shift used in the recurrence.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset. Sampled on `clk`; 0 resets the block.
- `start_init`  in  1  single-cycle request to (re)seed. Accepted only in IDLE or DONE.
- `seed_value`  in  32  seed. Captured on the cycle `start_init` is accepted.
- `write_en_init`  out  1  state-memory write strobe.
- `write_addr_init`  out  10  state-memory write address, 0..623.
- `write_data_init`  out  32  state-memory write data.
- `busy_init`  out  1  high while words are being written.
- `done_init`  out  1  level. High after word 623 is written; stays high until the next accepted start or reset.

## Operation
FSM states: IDLE, RUN, DONE.
- IDLE: all strobes low.
  - `start_init`=1 → capture the seed into `prev`, set `idx`=0, go to RUN.
- RUN: one word is written per cycle.
  - `idx`==0: write `seed` to address 0.
  - `idx`=i>0: write `w_i = INIT_MULT * (prev ^ (prev >> SHIFT)) + i` to address i. Multiply and add are modulo 2^32 (keep the low 32 bits). `i` is zero-extended to 32 bits.
  - After each write: `prev` ← the word just written, `idx` ← `idx`+1.
  - When `idx`==N-1 is written, go to DONE.
- DONE: `done_init`=1, `write_en_init`=0.
  - `start_init`=1 → clear `done_init`, recapture the seed, go to RUN.
- `start_init` during RUN is ignored. The seed is not re-sampled and the sequence continues.
- `seed_value` changing during RUN has no effect. Only the captured value is used.
- The recurrence depends on the previous word, so it cannot be pipelined. The 32×32 low-half multiply completes combinationally within one cycle.

## Timing
- Reset (`rst`=0 at a clock edge): state ← IDLE; `write_en_init`=0, `write_addr_init`=0, `write_data_init`=0, `busy_init`=0, `done_init`=0, internal `idx`=0, `prev`=0.
- Reset asserted mid-RUN aborts immediately. Memory contents are left partial. `done_init` must not assert until a full new sequence completes.
- Outputs are registered. If `start_init` is accepted at edge T0:
  - Edge T0+1: `write_en_init`=1, `write_addr_init`=0, `write_data_init`=seed, `busy_init`=1.
  - Edge T0+1+k: address k, for k = 0..623.
  - Edge T0+624: address 623 is presented.
  - Edge T0+625: `write_en_init`=0, `busy_init`=0, `done_init`=1.
- Total latency from start to done is 625 cycles. Writes are contiguous with no bubbles.
- `write_addr_init` never exceeds 623. No wrap-around; the counter stops at N-1.
- `done_init` and `busy_init` are never high together.
- `start_init` in the same cycle as reset low: reset wins.
- A restart accepted from DONE clears `done_init` on the same edge that presents address 0.

## Test plan
- Seed 5489 → addr 0 = 5489 (0x00001571), addr 1 = 1301868182 (0x4D98EE96). The full 624-word dump matches the C reference `init_genrand(5489)`.
- Seed 0 → addr 0 = 0, addr 1 = 1, addr 2 = 1812433255. Exactly 624 write strobes; `done_init` rises at T0+625.
- Seed 0xFFFFFFFF → addr 1 = `INIT_MULT * (0xFFFFFFFF ^ 0x3)` + 1 mod 2^32. This checks the shift-30 path and the 32-bit truncation.
- Pulse `start_init` at word 100 with a different seed → the sequence is unaffected; total writes = 624; all data matches the first seed.
- Drop `rst` low at word 300, release, then start seed 1 → outputs are zero during reset. A fresh run writes addr 1 = 1812433254. `done_init` stays low until the new run's word 623.
- From DONE, start seed 42 → `done_init` falls at the edge where address 0 is presented, and the 624 words match `init_genrand(42)`.

Source files
------------

// File: rtl/mt_seed_init.sv
// MT19937 seeding stage: expands a 32-bit seed into the 624-word state vector,
// writing one word per cycle into the shared state memory, then flags completion.
module mt_seed_init #(
  parameter int          N         = 624,
  parameter logic [31:0] INIT_MULT = 32'd1812433253,
  parameter int          SHIFT     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_init,
  input  logic [31:0] seed_value,
  output logic        write_en_init,
  output logic [9:0]  write_addr_init,
  output logic [31:0] write_data_init,
  output logic        busy_init,
  output logic        done_init
);

  localparam logic [9:0] LAST = 10'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] prev;
  logic [9:0]  idx;
  logic [31:0] mixed;
  logic [31:0] next_word;

  // Serial recurrence: each word depends on the one before, so the
  // low-half multiply must settle in a single cycle.
  always_comb begin
    mixed     = prev ^ (prev >> SHIFT);
    next_word = (idx == 10'd0) ? prev : (INIT_MULT * mixed + {22'd0, idx});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      prev            <= '0;
      idx             <= '0;
      write_en_init   <= 1'b0;
      write_addr_init <= '0;
      write_data_init <= '0;
      busy_init       <= 1'b0;
      done_init       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          write_en_init <= 1'b0;
          busy_init     <= 1'b0;
          if (start_init) begin
            prev  <= seed_value;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          write_en_init   <= 1'b1;
          write_addr_init <= idx;
          write_data_init <= next_word;
          busy_init       <= 1'b1;
          done_init       <= 1'b0;
          prev            <= next_word;
          // Counter parks at N-1; start requests are ignored until DONE.
          if (idx == LAST) state <= DONE;
          else             idx   <= idx + 10'd1;
        end
        DONE: begin
          write_en_init <= 1'b0;
          busy_init     <= 1'b0;
          done_init     <= 1'b1;
          if (start_init) begin
            prev  <= seed_value;
            idx   <= '0;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
